// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: sync hunt, width/height header, pixel stream.
// Optional checksum byte after the pixels: define UART_RX_FRAME_CSUM_EN.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk_i_frm,
  input  logic                  rst_i_frm,
  input  logic                  enable_i_frm,
  input  logic                  abort_i_frm,
  input  logic                  fifo_empty_i_frm,
  input  logic [DATA_WIDTH-1:0] fifo_data_i_frm,
  output logic                  fifo_rd_o_frm,
  output logic                  mem_we_o_frm,
  output logic [ADDR_WIDTH-1:0] mem_addr_o_frm,
  output logic [DATA_WIDTH-1:0] mem_data_o_frm,
  output logic [DATA_WIDTH-1:0] width_o_frm,
  output logic [DATA_WIDTH-1:0] height_o_frm,
  output logic                  busy_o_frm,
  output logic                  frame_done_o_frm,
  output logic                  err_o_frm
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_W_HDR  = 3'd2,
    S_H_HDR  = 3'd3,
    S_PIXELS = 3'd4,
    S_DONE   = 3'd5,
`ifdef UART_RX_FRAME_CSUM_EN
    S_ERR    = 3'd6,
    S_CSUM   = 3'd7
`else
    S_ERR    = 3'd6
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] width_q, width_d;
  logic [DATA_WIDTH-1:0] height_q, height_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [TW-1:0]         idle_q, idle_d;
`ifdef UART_RX_FRAME_CSUM_EN
  logic [DATA_WIDTH-1:0] xor_q, xor_d;
`endif

  logic          pop;
  logic          timed;
  logic [PW-1:0] prod;
  logic          too_big;
  logic          last_px;

  // Pop whenever a byte-consuming state sees data at the FIFO head
  always_comb begin
    timed = (state_q == S_W_HDR) || (state_q == S_H_HDR)
`ifdef UART_RX_FRAME_CSUM_EN
         || (state_q == S_CSUM)
`endif
         || (state_q == S_PIXELS);
    pop = !fifo_empty_i_frm && (timed || (state_q == S_SYNC));
  end

  // Frame geometry checks on the height byte and last-pixel detect
  always_comb begin
    prod    = {{DATA_WIDTH{1'b0}}, width_q}
            * {{DATA_WIDTH{1'b0}}, fifo_data_i_frm};
    too_big = 32'(prod) > (32'd1 << ADDR_WIDTH);
    last_px = (32'(idx_q) + 32'd1) == 32'(pcnt_q);
  end

  // Next-state and datapath updates; abort overrides everything
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    idx_d    = idx_q;
    pcnt_d   = pcnt_q;
    idle_d   = '0;
`ifdef UART_RX_FRAME_CSUM_EN
    xor_d    = xor_q;
`endif
    if (timed && !pop) idle_d = idle_q + TW'(1);
    unique case (state_q)
      S_IDLE: if (enable_i_frm) state_d = S_SYNC;
      S_SYNC: begin
        if (pop && fifo_data_i_frm == SYNC_BYTE) state_d = S_W_HDR;
      end
      S_W_HDR: begin
        if (pop) begin
          width_d = fifo_data_i_frm;
          state_d = S_H_HDR;
        end
      end
      S_H_HDR: begin
        if (pop) begin
          height_d = fifo_data_i_frm;
          if (width_q == '0 || fifo_data_i_frm == '0 || too_big) begin
            state_d = S_ERR;
          end else begin
            pcnt_d  = prod;
            idx_d   = '0;
`ifdef UART_RX_FRAME_CSUM_EN
            xor_d   = '0;
`endif
            state_d = S_PIXELS;
          end
        end
      end
      S_PIXELS: begin
        if (pop) begin
          we_d   = 1'b1;
          addr_d = idx_q;
          data_d = fifo_data_i_frm;
          idx_d  = idx_q + ADDR_WIDTH'(1);
`ifdef UART_RX_FRAME_CSUM_EN
          xor_d  = xor_q ^ fifo_data_i_frm;
          if (last_px) state_d = S_CSUM;
`else
          if (last_px) state_d = S_DONE;
`endif
        end
      end
`ifdef UART_RX_FRAME_CSUM_EN
      S_CSUM: begin
        if (pop) state_d = (fifo_data_i_frm == xor_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: state_d = enable_i_frm ? S_SYNC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timed && !pop && idle_q == TW'(TIMEOUT_CYC - 1)) state_d = S_ERR;
    if (abort_i_frm) begin
      state_d = S_IDLE;
      we_d    = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i_frm or posedge rst_i_frm) begin
    if (rst_i_frm) begin
      state_q  <= S_IDLE;
      width_q  <= '0;
      height_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      pcnt_q   <= '0;
      idle_q   <= '0;
`ifdef UART_RX_FRAME_CSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      pcnt_q   <= pcnt_d;
      idle_q   <= idle_d;
`ifdef UART_RX_FRAME_CSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  // Status decode straight from the state register
  always_comb begin
    fifo_rd_o_frm    = pop;
    mem_we_o_frm     = we_q;
    mem_addr_o_frm   = addr_q;
    mem_data_o_frm   = data_q;
    width_o_frm      = width_q;
    height_o_frm     = height_q;
    busy_o_frm       = (state_q == S_W_HDR) || (state_q == S_H_HDR)
                    || (state_q == S_PIXELS);
    frame_done_o_frm = (state_q == S_DONE);
    err_o_frm        = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a FWFT FIFO model.
// Write/done/err activity is logged on the falling edge.
module tb_uart_rx_frame_ctrl;

  logic       clk, rst, en, abort, gap;
  logic       fifo_empty, fifo_rd;
  logic [7:0] fifo_data;
  logic       we, busy, done, err;
  logic [15:0] addr;
  logic [7:0] wdata, width, height;

  logic [7:0] fb [0:255];
  int wr_n = 0;
  int rd_p = 0;
  int cyc = 0;
  int last_pop = 0;
  int err_edge = 0;
  int n_done = 0;
  int n_err = 0;
  int viol = 0;
  logic done_we = 0;
  logic [15:0] done_addr = 0;
  logic [15:0] wa [$];
  logic [7:0]  wd [$];
  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_frame_ctrl #(.TIMEOUT_CYC(50)) dut (
    .clk_i_frm(clk),
    .rst_i_frm(rst),
    .enable_i_frm(en),
    .abort_i_frm(abort),
    .fifo_empty_i_frm(fifo_empty),
    .fifo_data_i_frm(fifo_data),
    .fifo_rd_o_frm(fifo_rd),
    .mem_we_o_frm(we),
    .mem_addr_o_frm(addr),
    .mem_data_o_frm(wdata),
    .width_o_frm(width),
    .height_o_frm(height),
    .busy_o_frm(busy),
    .frame_done_o_frm(done),
    .err_o_frm(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  assign fifo_empty = gap || (rd_p >= wr_n);
  assign fifo_data  = fb[rd_p[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd && !fifo_empty) begin
      rd_p     <= rd_p + 1;
      last_pop <= cyc;
    end
  end

  always @(negedge clk) begin
    if (we) begin
      wa.push_back(addr);
      wd.push_back(wdata);
    end
    if (done) begin
      n_done    <= n_done + 1;
      done_we   <= we;
      done_addr <= addr;
    end
    if (err) begin
      n_err    <= n_err + 1;
      err_edge <= cyc - 1;
    end
    if (fifo_rd && fifo_empty) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [7:0] b);
    fb[wr_n[7:0]] = b;
    wr_n = wr_n + 1;
  endtask

  int bw, bd, be;

  task automatic snap();
    bw = wa.size();
    bd = n_done;
    be = n_err;
  endtask

  initial begin
    rst = 1; en = 0; abort = 0; gap = 0;
    run(2);
    chk("rst_outs",
        32'({fifo_rd, we, busy, done, err, addr, wdata}), 32'd0);
    chk("rst_hdr", 32'({width, height}), 32'd0);
    rst = 0;
    en = 1;
    run(2);

`ifdef UART_RX_FRAME_CSUM_EN
    snap();
    push(8'hA5); push(8'h01); push(8'h02);
    push(8'h0F); push(8'hF0); push(8'hFF);
    run(15);
    chk("cs_nwr", wa.size() - bw, 2);
    chk("cs_w0", 32'({wa[bw], wd[bw]}), 32'h0000_000F);
    chk("cs_w1", 32'({wa[bw+1], wd[bw+1]}), 32'h0000_01F0);
    chk("cs_done", n_done - bd, 1);
    chk("cs_done_we", 32'(done_we), 0);
    chk("cs_err", n_err - be, 0);
    snap();
    push(8'hA5); push(8'h01); push(8'h02);
    push(8'h0F); push(8'hF0); push(8'h00);
    run(15);
    chk("csb_nwr", wa.size() - bw, 2);
    chk("csb_done", n_done - bd, 0);
    chk("csb_err", n_err - be, 1);
`else
    snap();
    push(8'h3C); push(8'hA5); push(8'h02); push(8'h02);
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    run(30);
    chk("nf_nwr", wa.size() - bw, 4);
    for (int i = 0; i < 4; i++) begin
      if (wa.size() > bw + i)
        chk($sformatf("nf_w%0d", i), 32'({wa[bw+i], wd[bw+i]}),
            32'((i << 8) | ((i + 1) << 4)));
    end
    chk("nf_wh", 32'({width, height}), 32'h0202);
    chk("nf_done", n_done - bd, 1);
    chk("nf_done_wr", 32'({done_we, done_addr}), 32'h1_0003);
    chk("nf_err", n_err - be, 0);

    snap();
    push(8'hA5); push(8'h02); push(8'h02);
    run(6);
    for (int i = 1; i <= 4; i++) begin
      gap = 1;
      push(8'(i << 4));
      run(5);
      gap = 0;
      run(3);
    end
    run(5);
    chk("gap_nwr", wa.size() - bw, 4);
    for (int i = 0; i < 4; i++) begin
      if (wa.size() > bw + i)
        chk($sformatf("gap_w%0d", i), 32'({wa[bw+i], wd[bw+i]}),
            32'((i << 8) | ((i + 1) << 4)));
    end
    chk("gap_done", n_done - bd, 1);
    chk("gap_err", n_err - be, 0);
    chk("gap_viol", viol, 0);

    snap();
    push(8'hA5); push(8'h00); push(8'h05);
    run(8);
    chk("bh_err", n_err - be, 1);
    chk("bh_nwr", wa.size() - bw, 0);
    chk("bh_busy", 32'(busy), 0);
    push(8'hA5); push(8'h01); push(8'h01); push(8'h7F);
    run(10);
    chk("bh_nwr2", wa.size() - bw, 1);
    if (wa.size() > bw)
      chk("bh_w0", 32'({wa[bw], wd[bw]}), 32'h0000_007F);
    chk("bh_done", n_done - bd, 1);

    snap();
    push(8'hA5); push(8'h02); push(8'h01); push(8'h11);
    run(70);
    chk("to_err", n_err - be, 1);
    chk("to_delay", err_edge - last_pop, 50);
    chk("to_nwr", wa.size() - bw, 1);
    chk("to_done", n_done - bd, 0);

    snap();
    push(8'hA5); push(8'h02); push(8'h02); push(8'h10);
    run(8);
    gap = 1;
    push(8'h20);
    tick();
    gap = 0;
    abort = 1;
    en = 0;
    tick();
    abort = 0;
    chk("ab_busy", 32'(busy), 0);
    push(8'h30);
    run(3);
    chk("ab_idle_rd", 32'(fifo_rd), 0);
    chk("ab_nwr", wa.size() - bw, 1);
    chk("ab_err", n_err - be, 0);
    chk("ab_done", n_done - bd, 0);
    en = 1;
    run(5);

    push(8'hA5); push(8'h02); push(8'h02); push(8'h10);
    run(8);
    gap = 1;
    push(8'h20);
    run(2);
    chk("rm_busy", 32'(busy), 1);
    rst = 1;
    #1;
    chk("rm_outs",
        32'({fifo_rd, we, busy, done, err, addr, wdata}), 32'd0);
    chk("rm_hdr", 32'({width, height}), 32'd0);
    snap();
    tick();
    rst = 0;
    gap = 0;
    run(6);
    chk("rm_nwr", wa.size() - bw, 0);
    push(8'hA5); push(8'h01); push(8'h01); push(8'h55);
    run(10);
    chk("rm_nwr2", wa.size() - bw, 1);
    if (wa.size() > bw)
      chk("rm_w0", 32'({wa[bw], wd[bw]}), 32'h0000_0055);
    chk("rm_done", n_done - bd, 1);
    chk("rm_viol", viol, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller that drains the UART RX FIFO and writes image frames into the pixel buffer. It hunts for a sync byte, then captures a width byte and a height byte. It then streams exactly width*height pixel bytes to a memory write port with an auto-incrementing address. It sits between the RX FIFO read side (first-word-fall-through) and the image buffer, and reports done, busy and error status to the processing core.

Parameters:
DATA_WIDTH, 8, byte width of FIFO data and pixels
ADDR_WIDTH, 16, pixel buffer address width
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 100000, max idle clocks between bytes inside a frame before error

Ports:
clk_i_frm  in  1  system clock
rst_i_frm  in  1  asynchronous, active-high reset
enable_i_frm  in  1  allow new frame reception
abort_i_frm  in  1  synchronous abort, return to IDLE
fifo_empty_i_frm  in  1  RX FIFO empty
fifo_data_i_frm  in  DATA_WIDTH  RX FIFO head word, valid while empty low
fifo_rd_o_frm  out  1  pop strobe; head consumed at the same clock edge
mem_we_o_frm  out  1  pixel write strobe
mem_addr_o_frm  out  ADDR_WIDTH  pixel address
mem_data_o_frm  out  DATA_WIDTH  pixel data
width_o_frm  out  DATA_WIDTH  captured frame width
height_o_frm  out  DATA_WIDTH  captured frame height
busy_o_frm  out  1  high in W_HDR, H_HDR, PIXELS
frame_done_o_frm  out  1  1-cycle pulse, frame complete
err_o_frm  out  1  1-cycle pulse, frame error

Behaviour:
- Reset: clock and reset are one clock domain; reset is asynchronous, active-high. While reset is asserted, all outputs are 0, state is IDLE, and counters are cleared.
- fifo_rd_o_frm is combinational: high when state is in {SYNC, W_HDR, H_HDR, PIXELS, CSUM} and fifo_empty_i_frm is 0. At most one byte is popped per cycle. It is never high while the FIFO is empty.
- IDLE: if enable_i_frm is 1, go to SYNC next cycle.
- SYNC: on each pop, discard the byte. If the byte equals SYNC_BYTE, go to W_HDR. No timeout applies in SYNC.
- W_HDR: on pop, register width_o_frm and go to H_HDR.
- H_HDR: on pop, register height_o_frm.
  - If width=0, height=0, or width*height > 2^ADDR_WIDTH, go to ERR.
  - Otherwise load pixel count P = width*height (2*DATA_WIDTH-bit product), clear the address, and go to PIXELS.
- PIXELS: on each pop, next cycle mem_we_o_frm=1, mem_data_o_frm=popped byte, mem_addr_o_frm=current index. The index starts at 0 and increments by 1 per pixel. Latency from pop edge to write is 1 cycle.
  - The pop of pixel P-1 moves to DONE (or to CSUM when CHECKSUM_EN is defined).
- DONE: frame_done_o_frm=1 for one cycle, coincident with the final mem_we_o_frm. Next state is SYNC if enable_i_frm is 1, else IDLE.
- ERR: err_o_frm=1 for one cycle, then go to SYNC (enable=1) or IDLE. Writes already issued are not retracted.
- Timeout: in W_HDR, H_HDR, PIXELS and CSUM, an idle counter is cleared on every pop and incremented otherwise. On reaching TIMEOUT_CYC it forces ERR.
- abort_i_frm has priority over every transition. Next cycle: IDLE, no err pulse, no further writes; a write already scheduled from a pop in the abort cycle is suppressed.
- enable_i_frm is sampled only in IDLE, DONE and ERR. Deasserting it mid-frame does not stop the current frame.
- mem_we_o_frm, frame_done_o_frm and err_o_frm are 0 outside the cases above. mem_addr_o_frm and mem_data_o_frm hold their last values.

Optional Feature:
UART_RX_FRAME_CSUM_EN
- Defined: a running XOR of all pixel bytes is kept. After the last pixel, state CSUM pops one more byte.
  - If it equals the XOR, go to DONE; frame_done_o_frm pulses in the cycle after the CSUM pop, not with the final write.
  - Otherwise go to ERR.
- Undefined: CSUM state and accumulator are absent; the frame ends after pixel P-1 as described above.

Test Plan:
- Reset mid-frame: assert rst_i_frm during PIXELS -> all outputs 0 immediately, state IDLE, no further writes after release until a new A5 header arrives.
- Normal frame: enable=1, FIFO holds 3C,A5,02,02,10,20,30,40 -> 3C discarded; writes (0,10),(1,20),(2,30),(3,40); width=2, height=2; frame_done pulses with the write to addr 3.
- FIFO gaps: same frame with empty=1 for 5 cycles between pixels -> identical write sequence, fifo_rd never high while empty=1, no err.
- Bad header: A5,00,05 -> err pulse, zero writes, controller back in SYNC; a following A5,01,01,7F -> one write (0,7F) and done.
- Timeout/abort: TIMEOUT_CYC=50, A5,02,01,11 then silence -> err exactly 50 cycles after the 11 pop. Separately, abort during PIXELS -> IDLE next cycle, no err, no further writes.
- With UART_RX_FRAME_CSUM_EN: A5,01,02,0F,F0,FF -> done. With final byte 00 -> err, no done.
